// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: widths, reset defaults, fetch FSM
// encoding and the {instr, pc} entry handed to decode.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
// Decode handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the payload holds.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready,
    output misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready,
    input  misalign_err
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry skid FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t pop_data,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t [1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A push into a full FIFO is only accepted when a pop frees a slot
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, HOLD/RUN/FLUSH FSM, one in-flight read to a
// 1-cycle synchronous instruction memory, and a 2-entry skid FIFO to decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_stage_if.master bus,
  output logic [1:0]   dbg_state
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            misalign_q, misalign_d;

  logic            issue, push, pop;
  logic            fifo_full, fifo_empty;
  logic [1:0]      fifo_count;
  logic [2:0]      occupancy;
  fetch_entry_t    push_entry, head;

  // Slots that will be taken once this cycle's pop and in-flight response settle
  assign pop       = bus.out_ready && !fifo_empty;
  assign occupancy = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
  assign issue     = (state_q == ST_RUN) && !bus.redirect_valid && (occupancy < 3'd2);
  assign push      = inflight_q && !bus.redirect_valid;

  assign push_entry.instr = bus.imem_rdata;
  assign push_entry.pc    = req_pc_q;

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    misalign_d = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    if (bus.redirect_valid) begin
      state_d = ST_FLUSH;
      pc_d    = align_pc(bus.redirect_pc);
    end else begin
      case (state_q)
        ST_HOLD:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_HOLD;
      endcase
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HOLD;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(fifo_full && push && !pop));

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_instr    = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.out_pc       = fifo_empty ? '0 : head.pc;
  assign bus.misalign_err = misalign_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: startup latency, back-pressure, redirects,
// misaligned targets, high reset PC wrap and asynchronous reset.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [63:0] HI_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        reset_n;
  logic [1:0]  st1, st2;
  logic [31:0] imem_q;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_issue;
  logic [63:0] iss_q[$];
  logic [63:0] exp_q[$];

  fetch_stage_if bus();
  fetch_stage_if bus2();

  fetch_stage #(.RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(st1)
  );

  fetch_stage #(.RESET_PC(HI_PC)) u_dut_hi (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .dbg_state(st2)
  );

  // ---------------- clock / memory models ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req) imem_q <= imem_word(bus.imem_addr);
  end

  assign bus.imem_rdata      = imem_q;
  assign bus2.imem_rdata     = NOP_INSTR;
  assign bus2.out_ready      = 1'b1;
  assign bus2.redirect_valid = 1'b0;
  assign bus2.redirect_pc    = '0;

  // ---------------- checking / driving ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive this cycle's inputs just after the edge, then let logic settle
  task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
    @(posedge clk);
    #1;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, "_pc"}, bus.out_pc, v ? pc : 64'h0);
    check({tag, "_instr"}, 64'(bus.out_instr), 64'(v ? imem_word(pc) : NOP_INSTR));
  endtask

  task automatic check_req(input string tag, input logic req, input logic [63:0] addr);
    check({tag, "_req"}, 64'(bus.imem_req), 64'(req));
    if (req) check({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_out("rst", 1'b0, 64'h0);
    check("rst_req", 64'(bus.imem_req), 64'h0);
    check("rst_addr", bus.imem_addr, 64'h0);
    check("rst_misalign", 64'(bus.misalign_err), 64'h0);
    check("rst_state", 64'(st1), 64'(ST_HOLD));
    check("rst_hi_addr", bus2.imem_addr, HI_PC);

    // Startup with decode always ready
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("hold_req", 64'(bus.imem_req), 64'h0);
    step(1, 0, 0);
    check("c1_state", 64'(st1), 64'(ST_RUN));
    check_req("c1", 1'b1, 64'h0);
    check_out("c1", 1'b0, 0);
    check("c1_hi_addr", bus2.imem_addr, HI_PC);
    check("c1_hi_req", 64'(bus2.imem_req), 64'h1);
    step(1, 0, 0);
    check_req("c2", 1'b1, 64'h4);
    check_out("c2", 1'b0, 0);
    check("c2_hi_addr", bus2.imem_addr, 64'h0);
    step(1, 0, 0);
    check_req("c3", 1'b1, 64'h8);
    check_out("c3", 1'b1, 64'h0);
    check("c3_hi_addr", bus2.imem_addr, 64'h4);
    step(1, 0, 0);
    check_req("c4", 1'b1, 64'hC);
    check_out("c4", 1'b1, 64'h4);
    step(1, 0, 0);
    check_out("c5", 1'b1, 64'h8);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'h0);
    check("arst_req", 64'(bus.imem_req), 64'h0);
    check("arst_addr", bus.imem_addr, 64'h0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    reset_n       = 1'b1;
    #1;

    // Back-pressure: decode stalled for 6 cycles
    n_issue = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      if (bus.imem_req) begin
        n_issue++;
        iss_q.push_back(bus.imem_addr);
      end
      if (i >= 2) check_out("stall", 1'b1, 64'h0);
    end
    check("stall_issues", 64'(n_issue), 64'd2);
    check("stall_req_off", 64'(bus.imem_req), 64'h0);
    if (iss_q.size() == 2) begin
      check("stall_iss0", iss_q[0], 64'h0);
      check("stall_iss1", iss_q[1], 64'h4);
    end

    // Release: in-order delivery, nothing lost or duplicated
    exp_q = '{64'h0, 64'h4, 64'h8};
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      if (bus.out_valid && exp_q.size() > 0) begin
        check("order_pc", bus.out_pc, exp_q[0]);
        check("order_instr", 64'(bus.out_instr), 64'(imem_word(exp_q[0])));
        void'(exp_q.pop_front());
      end
    end
    check("order_drained", 64'(exp_q.size()), 64'h0);

    // Redirect with FIFO holding one entry and a fetch in flight
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    reset_n       = 1'b1;
    #1;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 64'h100);
    check("rd_pre_valid", 64'(bus.out_valid), 64'h1);
    check("rd_req", 64'(bus.imem_req), 64'h0);
    step(1, 0, 0);
    check("rd1_state", 64'(st1), 64'(ST_FLUSH));
    check_out("rd1", 1'b0, 0);
    check("rd1_req", 64'(bus.imem_req), 64'h0);
    check("rd1_misalign", 64'(bus.misalign_err), 64'h0);
    step(1, 0, 0);
    check_req("rd2", 1'b1, 64'h100);
    step(1, 0, 0);
    check_req("rd3", 1'b1, 64'h104);
    check_out("rd3", 1'b0, 0);
    step(1, 0, 0);
    check_out("rd4", 1'b1, 64'h100);
    step(1, 0, 0);
    check_out("rd5", 1'b1, 64'h104);

    // Misaligned redirect target
    step(1, 1, 64'h102);
    check("ma0_misalign", 64'(bus.misalign_err), 64'h0);
    check("ma0_req", 64'(bus.imem_req), 64'h0);
    step(1, 0, 0);
    check("ma1_misalign", 64'(bus.misalign_err), 64'h1);
    check_out("ma1", 1'b0, 0);
    step(1, 0, 0);
    check("ma2_misalign", 64'(bus.misalign_err), 64'h0);
    check_req("ma2", 1'b1, 64'h100);
    step(1, 0, 0);
    check_req("ma3", 1'b1, 64'h104);
    step(1, 0, 0);
    check_out("ma4", 1'b1, 64'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
